// File: rtl/inference_sequencer.sv
// inference_sequencer: steps a batch of samples from a synchronous sample memory
// through neural_net. Each sample is fetched, latched onto the network input and
// fired. The sequencer then waits for the result strobe, with a watchdog, and
// reports class, label and running scores.
module inference_sequencer #(
    parameter int IN_WIDTH       = 784,
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 7,
    parameter int CLASS_WIDTH    = 4,
    parameter int FIRST_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_WIDTH:0]            num_samples,
    output logic                           mem_rd,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic [IN_WIDTH*DATA_WIDTH-1:0] mem_data,
    input  logic [CLASS_WIDTH-1:0]         mem_label,
    output logic [IN_WIDTH*DATA_WIDTH-1:0] net_in,
    output logic                           net_first,
    input  logic                           net_done,
    input  logic [CLASS_WIDTH-1:0]         net_result,
    output logic                           res_valid,
    output logic [ADDR_WIDTH-1:0]          res_idx,
    output logic [CLASS_WIDTH-1:0]         res_class,
    output logic [CLASS_WIDTH-1:0]         res_label,
    output logic                           res_timeout,
    output logic [ADDR_WIDTH:0]            correct_count,
    output logic [ADDR_WIDTH:0]            timeout_count,
    output logic                           busy,
    output logic                           done
);
    localparam int VEC_W = IN_WIDTH * DATA_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FIR_W = $clog2(FIRST_CYCLES + 1);
    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(1 << ADDR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_FIRE, S_WAIT, S_REPORT, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]       n_q, n_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [FIR_W-1:0]       fire_q, fire_d;
    logic [VEC_W-1:0]       net_in_q, net_in_d;
    logic [CLASS_WIDTH-1:0] label_q, label_d;
    logic [ADDR_WIDTH-1:0]  res_idx_q, res_idx_d;
    logic [CLASS_WIDTH-1:0] res_class_q, res_class_d;
    logic [CLASS_WIDTH-1:0] res_label_q, res_label_d;
    logic                   res_to_q, res_to_d;
    logic [CNT_W-1:0]       correct_q, correct_d;
    logic [CNT_W-1:0]       tmo_q, tmo_d;
    logic [CNT_W-1:0]       n_clamp;

    // Batch length saturates at the memory depth.
    assign n_clamp = (num_samples > MAX_N) ? MAX_N : num_samples;

    // Next-state and datapath updates; everything holds unless a state says otherwise.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        n_d         = n_q;
        timer_d     = timer_q;
        fire_d      = fire_q;
        net_in_d    = net_in_q;
        label_d     = label_q;
        res_idx_d   = res_idx_q;
        res_class_d = res_class_q;
        res_label_d = res_label_q;
        res_to_d    = res_to_q;
        correct_d   = correct_q;
        tmo_d       = tmo_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    n_d       = n_clamp;
                    idx_d     = '0;
                    correct_d = '0;
                    tmo_d     = '0;
                    state_d   = (n_clamp == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                net_in_d = mem_data;
                label_d  = mem_label;
                fire_d   = '0;
                state_d  = S_FIRE;
            end
            S_FIRE: begin
                if (fire_q == FIR_W'(FIRST_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end else begin
                    fire_d = fire_q + FIR_W'(1);
                end
            end
            S_WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                // A result arriving in the last watchdog cycle still counts as a result.
                if (net_done || timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    res_idx_d   = idx_q;
                    res_label_d = label_q;
                    res_class_d = net_done ? net_result : '0;
                    res_to_d    = !net_done;
                    state_d     = S_REPORT;
                end
            end
            S_REPORT: begin
                if (res_to_q)
                    tmo_d = tmo_q + CNT_W'(1);
                else if (res_class_q == res_label_q)
                    correct_d = correct_q + CNT_W'(1);
                if ({1'b0, idx_q} == n_q - CNT_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + ADDR_WIDTH'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            n_q         <= '0;
            timer_q     <= '0;
            fire_q      <= '0;
            net_in_q    <= '0;
            label_q     <= '0;
            res_idx_q   <= '0;
            res_class_q <= '0;
            res_label_q <= '0;
            res_to_q    <= 1'b0;
            correct_q   <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            n_q         <= n_d;
            timer_q     <= timer_d;
            fire_q      <= fire_d;
            net_in_q    <= net_in_d;
            label_q     <= label_d;
            res_idx_q   <= res_idx_d;
            res_class_q <= res_class_d;
            res_label_q <= res_label_d;
            res_to_q    <= res_to_d;
            correct_q   <= correct_d;
            tmo_q       <= tmo_d;
        end
    end

    // Strobes decode straight from state, so reset drops them immediately.
    assign mem_rd        = (state_q == S_FETCH);
    assign mem_addr      = idx_q;
    assign net_in        = net_in_q;
    assign net_first     = (state_q == S_FIRE);
    assign res_valid     = (state_q == S_REPORT);
    assign res_idx       = res_idx_q;
    assign res_class     = res_class_q;
    assign res_label     = res_label_q;
    assign res_timeout   = res_to_q;
    assign correct_count = correct_q;
    assign timeout_count = tmo_q;
    assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done          = (state_q == S_DONE);
endmodule

// File: tb/tb_inference_sequencer.sv
// Directed bench for inference_sequencer with a sample-memory model and a
// neural_net stand-in whose result delay and drop pattern are set per test.
module tb_inference_sequencer;
    localparam int IN = 784, DW = 16, AW = 7, CW = 4;
    localparam int VW = IN * DW;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [AW:0]   num_samples = '0;
    logic          mem_rd, net_first, res_valid, res_timeout, busy, done;
    logic          net_done = 1'b0;
    logic [AW-1:0] mem_addr, res_idx;
    logic [VW-1:0] mem_data = '0, net_in;
    logic [CW-1:0] mem_label = '0, net_result, res_class, res_label;
    logic [AW:0]   correct_count, timeout_count;

    inference_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .mem_label(mem_label),
        .net_in(net_in), .net_first(net_first), .net_done(net_done), .net_result(net_result),
        .res_valid(res_valid), .res_idx(res_idx), .res_class(res_class), .res_label(res_label),
        .res_timeout(res_timeout), .correct_count(correct_count), .timeout_count(timeout_count),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] mkvec(input int a);
        logic [VW-1:0] v;
        for (int j = 0; j < IN; j++) v[j*DW +: DW] = DW'(a * 1024 + j);
        return v;
    endfunction

    // Sample memory: one-cycle read latency.
    logic [CW-1:0] labels [128];
    logic [CW-1:0] results[128];
    logic [127:0]  nodone = '0;
    logic [AW-1:0] cur = '0;
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_data  <= mkvec(int'(mem_addr));
            mem_label <= labels[mem_addr];
            cur       <= mem_addr;
        end
    end
    assign net_result = results[cur];

    // Network stand-in: strobe net_done in WAIT cycle number dly (0 = first cycle after FIRE).
    int dly = 802, wcnt = 0;
    bit armed = 0, force_fire = 0;
    always @(negedge clk) begin
        if (rst) begin
            armed = 0; net_done = 1'b0;
        end else if (net_first) begin
            armed = 1; wcnt = 0; net_done = force_fire;
        end else if (armed) begin
            net_done = (wcnt == dly) && !nodone[cur];
            if (wcnt == dly) armed = 0;
            wcnt++;
        end else begin
            net_done = 1'b0;
        end
    end

    // Monitor: records report strobes, net_first pulse widths and read counts.
    int cyc = 0, nrd = 0, nres = 0, nfall = 0, flen = 0;
    bit prev_first = 0;
    int r_idx[512], r_cls[512], r_lab[512], r_to[512], r_cyc[512], fl[512], fall_cyc[512];
    always @(negedge clk) begin
        cyc++;
        if (mem_rd) nrd++;
        if (net_first) flen++;
        else if (prev_first) begin
            fl[nfall] = flen; fall_cyc[nfall] = cyc; nfall++; flen = 0;
        end
        prev_first = net_first;
        if (res_valid) begin
            r_idx[nres] = int'(res_idx); r_cls[nres] = int'(res_class);
            r_lab[nres] = int'(res_label); r_to[nres] = int'(res_timeout);
            r_cyc[nres] = cyc; nres++;
        end
    end

    task automatic do_start(input int n);
        @(negedge clk);
        start = 1'b1; num_samples = (AW+1)'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int k = 0;
        while (!done && k < maxc) begin @(negedge clk); #1; k++; end
        chk("done_reached", done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    int rb, fb, db;
    initial begin
        for (int i = 0; i < 128; i++) labels[i] = CW'(i % 10);
        labels[0] = 7; labels[1] = 2; labels[2] = 1;
        for (int i = 0; i < 128; i++) results[i] = labels[i];

        // Reset state
        #12;
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_first", net_first, 0);
        chk("rst_netin_zero", net_in == '0, 1); chk("rst_memrd", mem_rd, 0);
        @(negedge clk); rst = 1'b0;

        // Three good samples, with start-to-output latency
        rb = nres; fb = nfall;
        do_start(3);
        chk("lat_memrd_T1", mem_rd, 1); chk("lat_addr_T1", mem_addr, 0); chk("lat_busy", busy, 1);
        @(posedge clk); #1;
        chk("lat_first_T2", net_first, 0);
        @(posedge clk); #1;
        chk("lat_first_T3", net_first, 1);
        chk("lat_netin_T3", net_in == mkvec(0), 1);
        wait_done(5000);
        chk("t1_nres", nres - rb, 3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_idx", r_idx[rb+i], i);
            chk("t1_firstlen", fl[fb+i], 2);
        end
        chk("t1_gap", r_cyc[rb] - fall_cyc[fb], 803);
        chk("t1_correct", correct_count, 3); chk("t1_tmo", timeout_count, 0);
        chk("t1_busy", busy, 0);

        // Misclassified middle sample; restart from DONE clears counters
        results[1] = 3;
        rb = nres;
        do_start(3);
        chk("t2_cnt_cleared", correct_count, 0); chk("t2_done_left", done, 0);
        wait_done(5000);
        chk("t2_correct", correct_count, 2);
        chk("t2_cls1", r_cls[rb+1], 3); chk("t2_lab1", r_lab[rb+1], 2);
        results[1] = 2;

        // First of two samples never answers
        nodone[0] = 1'b1;
        rb = nres; fb = nfall;
        do_start(2);
        wait_done(5000);
        chk("t3_nres", nres - rb, 2);
        chk("t3_to0", r_to[rb], 1); chk("t3_cls0", r_cls[rb], 0);
        chk("t3_gap", r_cyc[rb] - fall_cyc[fb], 1023);
        chk("t3_to1", r_to[rb+1], 0); chk("t3_idx1", r_idx[rb+1], 1);
        chk("t3_tmo", timeout_count, 1); chk("t3_correct", correct_count, 1);
        nodone[0] = 1'b0;

        // Result in final watchdog cycle wins; net_done during FIRE is ignored
        dly = 1022; force_fire = 1;
        rb = nres; fb = nfall;
        do_start(1);
        wait_done(5000);
        chk("t4_nres", nres - rb, 1);
        chk("t4_to", r_to[rb], 0); chk("t4_cls", r_cls[rb], 7);
        chk("t4_gap", r_cyc[rb] - fall_cyc[fb], 1023);
        chk("t4_tmo", timeout_count, 0); chk("t4_correct", correct_count, 1);
        force_fire = 0;

        // Empty batch
        db = nrd; rb = nres;
        do_start(0);
        chk("t5_done", done, 1); chk("t5_busy", busy, 0); chk("t5_correct", correct_count, 0);
        repeat (4) @(negedge clk);
        #1 chk("t5_no_rd", nrd - db, 0); chk("t5_no_res", nres - rb, 0);

        // Oversized batch clamps to 128; start mid-batch is ignored
        dly = 2;
        db = nrd; rb = nres;
        do_start(200);
        repeat (30) @(negedge clk);
        start = 1'b1; num_samples = 5;
        @(negedge clk); start = 1'b0;
        chk("t6_busy_mid", busy, 1);
        wait_done(20000);
        chk("t6_nres", nres - rb, 128); chk("t6_nrd", nrd - db, 128);
        chk("t6_last_idx", r_idx[nres-1], 127);
        chk("t6_correct", correct_count, 128); chk("t6_tmo", timeout_count, 0);

        // Reset during WAIT of the second sample
        dly = 802;
        rb = nres;
        do_start(3);
        while (nres == rb && cyc < 100000) @(negedge clk);
        repeat (20) @(negedge clk);
        #1 chk("t7_pre_busy", busy, 1); chk("t7_pre_correct", correct_count, 1);
        rst = 1'b1; #1;
        chk("t7_busy", busy, 0); chk("t7_done", done, 0); chk("t7_first", net_first, 0);
        chk("t7_memrd", mem_rd, 0); chk("t7_resv", res_valid, 0);
        chk("t7_netin_zero", net_in == '0, 1); chk("t7_correct", correct_count, 0);
        chk("t7_tmo", timeout_count, 0); chk("t7_residx", res_idx, 0);
        chk("t7_rescls", res_class, 0); chk("t7_reslab", res_label, 0);
        chk("t7_addr", mem_addr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dly = 2; rb = nres;
        do_start(1);
        chk("t7_re_addr", mem_addr, 0); chk("t7_re_correct", correct_count, 0);
        wait_done(2000);
        chk("t7_re_idx", r_idx[rb], 0); chk("t7_re_final", correct_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
